// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues data-memory requests, stalls upstream while
// an access is outstanding, aborts on timeout and registers results into MEM/WB.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | no access outstanding; an aligned access requests this cycle
//   S_WAIT | request held, waiting for dmem_ack or the timeout count
module mem_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        regwriteM,
   input  logic        memwriteM,
   input  logic [1:0]  resultsrcM,
   input  logic [31:0] aluresultM,
   input  logic [31:0] writedataM,
   input  logic [31:0] pcplus4M,
   input  logic [4:0]  rdM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        stallM,
   output logic        errM,
   output logic        regwriteW,
   output logic [1:0]  resultsrcW,
   output logic [31:0] aluresultW,
   output logic [31:0] readdataW,
   output logic [31:0] pcplus4W,
   output logic [4:0]  rdW
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   localparam logic [7:0] TC = 8'(TIMEOUT - 1);

   state_t     state, state_nx;
   logic [7:0] cnt, cnt_nx;
   logic       access, misaligned, req_ok;
   logic       ack_ok, abort, fail;

   assign access     = memwriteM | (resultsrcM == 2'b01);
   assign misaligned = access & (aluresultM[1:0] != 2'b00);
   assign req_ok     = access & ~misaligned;
   assign fail       = misaligned | abort;

   assign dmem_we    = memwriteM;
   assign dmem_addr  = aluresultM;
   assign dmem_wdata = writedataM;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         cnt   <= 8'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         S_IDLE: begin
            if (req_ok && !dmem_ack) begin
               state_nx = S_WAIT;
               cnt_nx   = 8'd1;
            end else begin
               cnt_nx   = 8'd0;
            end
         end
         S_WAIT: begin
            if (dmem_ack || abort) begin
               state_nx = S_IDLE;
               cnt_nx   = 8'd0;
            end else begin
               cnt_nx   = cnt + 8'd1;
            end
         end
         default: begin
            state_nx = S_IDLE;
            cnt_nx   = 8'd0;
         end
      endcase
   end

   // Request and stall are forced low while reset is held, whatever the inputs.
   always_comb begin
      dmem_req = 1'b0;
      abort    = 1'b0;
      case (state)
         S_IDLE:  dmem_req = req_ok;
         S_WAIT: begin
            dmem_req = 1'b1;
            abort    = (cnt == TC) & ~dmem_ack;
         end
         default: dmem_req = 1'b0;
      endcase
      if (!rst) begin
         dmem_req = 1'b0;
         abort    = 1'b0;
      end
      ack_ok = dmem_req & dmem_ack;
      stallM = rst & req_ok & ~ack_ok & ~abort;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         errM       <= 1'b0;
         regwriteW  <= 1'b0;
         resultsrcW <= 2'b00;
         aluresultW <= 32'd0;
         readdataW  <= 32'd0;
         pcplus4W   <= 32'd0;
         rdW        <= 5'd0;
      end else begin
         errM <= ~stallM & fail;
         if (stallM) begin
            regwriteW <= 1'b0;
         end else begin
            regwriteW  <= regwriteM & ~fail;
            resultsrcW <= resultsrcM;
            aluresultW <= aluresultM;
            pcplus4W   <= pcplus4M;
            rdW        <= rdM;
         end
         if (ack_ok && !memwriteM)
            readdataW <= dmem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: fixed vector table, reset-during-wait sequence and a
// randomized run checked against a per-instruction outcome model.
module tb_mem_stage;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        regwriteM, memwriteM;
   logic [1:0]  resultsrcM;
   logic [31:0] aluresultM, writedataM, pcplus4M;
   logic [4:0]  rdM;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        dmem_ack;
   logic        stallM, errM, regwriteW;
   logic [1:0]  resultsrcW;
   logic [31:0] aluresultW, readdataW, pcplus4W;
   logic [4:0]  rdW;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_stage #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .regwriteM(regwriteM), .memwriteM(memwriteM), .resultsrcM(resultsrcM),
      .aluresultM(aluresultM), .writedataM(writedataM), .pcplus4M(pcplus4M), .rdM(rdM),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .stallM(stallM), .errM(errM), .regwriteW(regwriteW), .resultsrcW(resultsrcW),
      .aluresultW(aluresultW), .readdataW(readdataW), .pcplus4W(pcplus4W), .rdW(rdW)
   );

   typedef struct {
      logic        regw;
      logic        mw;
      logic [1:0]  rs;
      logic [31:0] alu;
      logic [31:0] wd;
      logic [31:0] pc;
      logic [4:0]  rd;
      int          lat;     // cycle index of ack; >= TO means never
      logic [31:0] rdata;
   } instr_t;

   typedef struct {
      int          stall;   // number of stalled cycles before completion
      bit          req;
      bit          err;
      bit          regw;
      logic [31:0] rdata;   // readdataW after completion
   } exp_t;

   typedef struct {
      instr_t i;
      exp_t   e;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input instr_t r, input bit ack, input logic [31:0] rdata);
      regwriteM  = r.regw;
      memwriteM  = r.mw;
      resultsrcM = r.rs;
      aluresultM = r.alu;
      writedataM = r.wd;
      pcplus4M   = r.pc;
      rdM        = r.rd;
      dmem_ack   = ack;
      dmem_rdata = rdata;
   endtask

   // Outcome of one instruction derived from the stage's rules, not its structure.
   function automatic exp_t model(input instr_t r, input logic [31:0] prev_rd);
      exp_t e;
      bit   access, mis;
      access  = r.mw || (r.rs == 2'b01);
      mis     = access && (r.alu[1:0] != 2'b00);
      e.rdata = prev_rd;
      e.req   = access && !mis;
      if (!access) begin
         e.stall = 0; e.err = 0; e.regw = r.regw;
      end else if (mis) begin
         e.stall = 0; e.err = 1; e.regw = 0;
      end else if (r.lat <= TO - 1) begin
         e.stall = r.lat; e.err = 0; e.regw = r.regw;
         if (!r.mw) e.rdata = r.rdata;
      end else begin
         e.stall = TO - 1; e.err = 1; e.regw = 0;
      end
      return e;
   endfunction

   task automatic run_instr(input string tag, input instr_t r, input exp_t e);
      for (int k = 0; k <= e.stall; k++) begin
         @(negedge clk);
         drive(r, k == r.lat, (k == r.lat) ? r.rdata : $urandom);
         #1;
         chk({tag, " stallM"},   32'(stallM),   32'(k < e.stall));
         chk({tag, " dmem_req"}, 32'(dmem_req), 32'(e.req));
         if (e.req) begin
            chk({tag, " dmem_we"},    32'(dmem_we), 32'(r.mw));
            chk({tag, " dmem_addr"},  dmem_addr,    r.alu);
            chk({tag, " dmem_wdata"}, dmem_wdata,   r.wd);
         end
         @(posedge clk);
         #1;
         if (k < e.stall) begin
            chk({tag, " bubble regwriteW"}, 32'(regwriteW), 32'd0);
            chk({tag, " bubble errM"},      32'(errM),      32'd0);
         end else begin
            chk({tag, " regwriteW"},  32'(regwriteW),  32'(e.regw));
            chk({tag, " errM"},       32'(errM),       32'(e.err));
            chk({tag, " resultsrcW"}, 32'(resultsrcW), 32'(r.rs));
            chk({tag, " aluresultW"}, aluresultW,      r.alu);
            chk({tag, " pcplus4W"},   pcplus4W,        r.pc);
            chk({tag, " rdW"},        32'(rdW),        32'(r.rd));
            chk({tag, " readdataW"},  readdataW,       e.rdata);
         end
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " dmem_req"},   32'(dmem_req),   32'd0);
      chk({tag, " stallM"},     32'(stallM),     32'd0);
      chk({tag, " errM"},       32'(errM),       32'd0);
      chk({tag, " regwriteW"},  32'(regwriteW),  32'd0);
      chk({tag, " resultsrcW"}, 32'(resultsrcW), 32'd0);
      chk({tag, " aluresultW"}, aluresultW,      32'd0);
      chk({tag, " readdataW"},  readdataW,       32'd0);
      chk({tag, " pcplus4W"},   pcplus4W,        32'd0);
      chk({tag, " rdW"},        32'(rdW),        32'd0);
   endtask

   vec_t        vecs [9];
   instr_t      ri;
   exp_t        re;
   logic [31:0] model_rd;

   initial begin
      //            regw  mw    rs     alu           wd            pc            rd     lat  rdata
      vecs[0].i = '{1'b1, 1'b0, 2'b01, 32'h0000_0010, 32'h0,        32'h0000_1004, 5'd5,  0,   32'hDEAD_BEEF};
      vecs[0].e = '{0,  1, 0, 1, 32'hDEAD_BEEF};
      vecs[1].i = '{1'b0, 1'b1, 2'b00, 32'h0000_0020, 32'h1234_5678, 32'h0000_1008, 5'd0,  3,   32'hAAAA_5555};
      vecs[1].e = '{3,  1, 0, 0, 32'hDEAD_BEEF};
      vecs[2].i = '{1'b1, 1'b0, 2'b00, 32'h0000_0042, 32'h0,        32'h0000_100C, 5'd7,  0,   32'h1111_1111};
      vecs[2].e = '{0,  0, 0, 1, 32'hDEAD_BEEF};
      vecs[3].i = '{1'b1, 1'b0, 2'b01, 32'h0000_0013, 32'h0,        32'h0000_1010, 5'd3,  0,   32'h2222_2222};
      vecs[3].e = '{0,  0, 1, 0, 32'hDEAD_BEEF};
      vecs[4].i = '{1'b1, 1'b0, 2'b01, 32'h0000_0040, 32'h0,        32'h0000_1014, 5'd4,  255, 32'h3333_3333};
      vecs[4].e = '{15, 1, 1, 0, 32'hDEAD_BEEF};
      vecs[5].i = '{1'b1, 1'b0, 2'b01, 32'h0000_0044, 32'h0,        32'h0000_1018, 5'd6,  15,  32'hCAFE_F00D};
      vecs[5].e = '{15, 1, 0, 1, 32'hCAFE_F00D};
      vecs[6].i = '{1'b1, 1'b0, 2'b10, 32'h0000_0000, 32'h0,        32'h0000_0100, 5'd1,  0,   32'h4444_4444};
      vecs[6].e = '{0,  0, 0, 1, 32'hCAFE_F00D};
      vecs[7].i = '{1'b1, 1'b1, 2'b00, 32'h0000_0022, 32'h5555_AAAA, 32'h0000_1020, 5'd2,  0,   32'h6666_6666};
      vecs[7].e = '{0,  0, 1, 0, 32'hCAFE_F00D};
      vecs[8].i = '{1'b1, 1'b0, 2'b01, 32'h0000_0080, 32'h0,        32'h0000_1024, 5'd31, 1,   32'h0BAD_F00D};
      vecs[8].e = '{1,  1, 0, 1, 32'h0BAD_F00D};

      // Reset held with an aligned load presented: request and stall must stay low.
      rst = 1'b0;
      drive(vecs[0].i, 1'b0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      for (int v = 0; v < 9; v++)
         run_instr($sformatf("vec%0d", v), vecs[v].i, vecs[v].e);

      // Reset asserted during the second WAIT cycle of an unacknowledged load.
      ri = '{1'b1, 1'b0, 2'b01, 32'h0000_0050, 32'h0, 32'h0000_2000, 5'd9, 2, 32'h5A5A_5A5A};
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive(ri, 1'b0, $urandom);
      end
      #1;
      chk("pre-reset stallM", 32'(stallM), 32'd1);
      rst = 1'b0;
      #1;
      chk_all_zero("mid-wait reset");
      @(posedge clk);
      #1;
      chk_all_zero("mid-wait reset held");
      @(negedge clk);
      rst = 1'b1;
      model_rd = 32'h0;
      re = model(ri, model_rd);
      run_instr("reissue", ri, re);
      model_rd = re.rdata;

      for (int n = 0; n < 80; n++) begin
         ri.regw  = 1'($urandom);
         ri.mw    = ($urandom_range(0, 3) == 0);
         ri.rs    = 2'($urandom_range(0, 2));
         ri.alu   = $urandom;
         if ($urandom_range(0, 3) != 0) ri.alu[1:0] = 2'b00;
         ri.wd    = $urandom;
         ri.pc    = $urandom;
         ri.rd    = 5'($urandom);
         ri.lat   = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, TO + 1);
         ri.rdata = $urandom;
         re = model(ri, model_rd);
         run_instr($sformatf("rand%0d", n), ri, re);
         model_rd = re.rdata;
      end

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage pipeline; consumes the EX/MEM register outputs (regwriteM, memwriteM, resultsrcM, aluresultM, writedataM, pcplus4M, rdM).
- Drives a word-wide data-memory request/acknowledge bus with variable latency.
- Stalls the upstream pipeline while an access is outstanding.
- Registers results into the MEM/WB pipeline register for the writeback stage.

Parameters:
- TIMEOUT, 16: max cycles dmem_req stays high without dmem_ack before the access is aborted (range 2..255).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- regwriteM  in  1  register-write enable from EX/MEM
- memwriteM  in  1  store indicator
- resultsrcM  in  2  00 ALU result, 01 load data, 10 pc+4
- aluresultM  in  32  effective address / ALU result
- writedataM  in  32  store data
- pcplus4M  in  32  pc+4 of instruction
- rdM  in  5  destination register
- dmem_req  out  1  access request
- dmem_we  out  1  1=store, 0=load
- dmem_addr  out  32  word address (=aluresultM)
- dmem_wdata  out  32  store data (=writedataM)
- dmem_rdata  in  32  load data, valid when dmem_ack=1
- dmem_ack  in  1  access complete this cycle
- stallM  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
- errM  out  1  one-cycle pulse: misaligned or timed-out access
- regwriteW  out  1  MEM/WB register-write enable
- resultsrcW  out  2  MEM/WB result select
- aluresultW  out  32  MEM/WB ALU result
- readdataW  out  32  MEM/WB load data
- pcplus4W  out  32  MEM/WB pc+4
- rdW  out  5  MEM/WB destination

Behaviour:
- access = memwriteM | (resultsrcM==01).
- misaligned = access & (aluresultM[1:0]!=00).
- FSM states are IDLE and WAIT; the counter is 8 bits.
- IDLE:
  - access & ~misaligned: dmem_req=1.
  - ack the same cycle: complete, stay IDLE.
  - no ack: go to WAIT with cnt=1.
- WAIT:
  - dmem_req=1.
  - ack: complete, go to IDLE.
  - cnt==TIMEOUT-1 & ~ack: abort, go to IDLE.
  - otherwise cnt+1.
- dmem_we=memwriteM, dmem_addr=aluresultM, dmem_wdata=writedataM (combinational). The bus sees them stable because EX/MEM is frozen by stallM.
- stallM = access & ~misaligned & ~ack & ~abort. It is combinational and never asserted for non-access instructions.
- Completion cycle (ack, abort, misaligned, or non-access instruction): stallM=0, so upstream advances on the next edge.
- MEM/WB register:
  - On an edge with stallM=0, load regwriteW, resultsrcW, aluresultW, pcplus4W, rdW from their M inputs.
  - readdataW loads dmem_rdata only when ack & ~memwriteM; otherwise it holds.
- Bubble: on an edge with stallM=1, regwriteW<=0 (other W fields hold), so WB never double-writes.
- Abort or misaligned:
  - regwriteW<=0 for that instruction; the store is not performed (no request for misaligned).
  - errM is registered, high for exactly one cycle after the completion edge.
- A late ack arriving in IDLE after an abort is ignored when access=0.
- dmem_rdata is ignored for stores.
- An ack arriving on the same cycle as the timeout takes priority: normal completion, no errM.
- Reset (rst=0, async, any state including WAIT):
  - FSM→IDLE, cnt=0, errM=0.
  - All W outputs 0: regwriteW=0, resultsrcW=00, aluresultW/readdataW/pcplus4W=0, rdW=0.
  - dmem_req=0 and stallM=0 while in reset.
  - A pending access is dropped; after release a still-present access re-issues from IDLE.

Test Plan:
- Load, addr 0x0000_0010, ack in same cycle with rdata 0xDEAD_BEEF, rd=5 -> stallM never high; next cycle readdataW=0xDEADBEEF, regwriteW=1, rdW=5, resultsrcW=01.
- Store, addr 0x20, wdata 0x1234_5678, ack after 3 cycles -> dmem_req/we high 4 cycles with constant addr/wdata; stallM high 3 cycles; regwriteW=0 during the stall bubbles; no errM.
- ALU instruction, resultsrcM=00, aluresultM=0x42, rd=7 -> dmem_req=0, stallM=0; next cycle aluresultW=0x42, regwriteW=1, rdW=7.
- Load at addr 0x0000_0013 -> dmem_req=0, stallM=0; next cycle errM=1 for one cycle and regwriteW=0.
- Load with TIMEOUT=16 and no ack -> stallM high 15 cycles, dmem_req drops after cycle 16; errM pulses once; regwriteW=0; FSM back in IDLE.
- Assert rst low in the 2nd WAIT cycle -> dmem_req, stallM, and all W outputs 0 immediately; after release the access re-issues and completes on ack with correct readdataW.
